// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
// Contents:
//   LEN_WORD          width of the length word and of each instruction word
//   DEFAULT_ACK_BYTE  reply byte for a successful (or empty) load
//   DEFAULT_NAK_BYTE  reply byte for a rejected length
//   state_t           one-hot loader states (5 bits)
//   max_words()       largest program size accepted for a given address width
package prog_loader_pkg;

  localparam int LEN_WORD = 32;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
  localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h55;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_LEN  = 5'b00010,
    S_DATA = 5'b00100,
    S_ACK  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  // A program may fill the whole instruction memory, i.e. 2^addr_w words.
  function automatic logic [LEN_WORD-1:0] max_words(input int addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: assembles a big-endian 32-bit word from a stream of bytes.
// Ports:
//   clk, rstn    clock and asynchronous active-low reset
//   clear        synchronous restart of the byte counter and shift register
//   byte_in      incoming byte
//   byte_valid   byte_in is valid this cycle
//   word_out     assembled word; first byte of the group in [31:24]
//   word_valid   one-cycle pulse alongside the 4th byte of each group
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic [LEN_WORD-1:0] word_out,
  output logic                word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  // Only the first three bytes need storage; the 4th is taken straight from
  // byte_in so the word is available in the same cycle it completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= 2'd0;
      shift_q  <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      shift_q  <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[15:0], byte_in};
    end
  end

  assign word_out   = {shift_q, byte_in};
  assign word_valid = byte_valid && (byte_cnt == 2'd3) && !clear;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: turns a UART byte stream (32-bit word count followed by that
// many 32-bit words, all big-endian) into instruction-memory writes, then
// replies with a single ack or nak byte.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   start                          one-cycle pulse that begins a load
//   rx_data, rx_valid              received byte stream
//   imem_we, imem_addr, imem_wdata instruction-memory write port
//   tx_data, tx_write, tx_accepted reply byte handshake with the transmitter
//   busy                           load in progress (LEN through ACK)
//   done                           sticky, load finished and reply sent
//   err                            sticky, length rejected
//   words_loaded                   number of words written so far
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W   = 15,
  parameter logic [7:0] ACK_BYTE = DEFAULT_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE = DEFAULT_NAK_BYTE
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [LEN_WORD-1:0] imem_wdata,
  output logic [7:0]          tx_data,
  output logic                tx_write,
  input  logic                tx_accepted,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam logic [LEN_WORD-1:0] MAX_LEN = max_words(ADDR_W);

  state_t              state;
  logic [LEN_WORD-1:0] len;
  logic                start_ok;
  logic                byte_ok;
  logic [LEN_WORD-1:0] word;
  logic                word_valid;
  logic [ADDR_W:0]     next_loaded;

  // start is honoured only when no load is running; bytes only while the
  // length or data words are expected.
  assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));
  assign byte_ok     = rx_valid && ((state == S_LEN) || (state == S_DATA));
  assign next_loaded = words_loaded + (ADDR_W + 1)'(1);

  byte_packer u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (start_ok),
    .byte_in    (rx_data),
    .byte_valid (byte_ok),
    .word_out   (word),
    .word_valid (word_valid)
  );

  // Main sequencer. The data path enters ACK with tx_write still low so the
  // request rises one cycle after the last write pulse; the length path sets
  // tx_write directly since nothing else happens in that cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      len          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      tx_data      <= 8'd0;
      tx_write     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_LEN;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
          end
        end
        S_LEN: begin
          if (word_valid) begin
            len <= word;
            if (word == '0) begin
              state    <= S_ACK;
              tx_data  <= ACK_BYTE;
              tx_write <= 1'b1;
            end else if (word > MAX_LEN) begin
              state    <= S_ACK;
              tx_data  <= NAK_BYTE;
              tx_write <= 1'b1;
              err      <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_valid) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= word;
            words_loaded <= next_loaded;
            if (LEN_WORD'(next_loaded) == len) begin
              state   <= S_ACK;
              tx_data <= ACK_BYTE;
            end
          end
        end
        S_ACK: begin
          if (tx_write) begin
            if (tx_accepted) begin
              tx_write <= 1'b0;
              state    <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            tx_write <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          tx_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (ADDR_W=4 so the oversize and full-memory
// boundaries are reachable with short streams).
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW = 4;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [7:0]    tx_data;
  logic          tx_write;
  logic          tx_accepted;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  int total = 0;
  int bad   = 0;

  // Write/transmit log filled on the falling edge, away from the active edge.
  int          wr_count = 0;
  int          tx_count = 0;
  logic [AW-1:0] wr_addr [0:255];
  logic [31:0]   wr_data [0:255];
  logic [7:0]    tx_last = 8'd0;

  int wr_base;
  int tx_base;

  prog_loader #(.ADDR_W(AW), .ACK_BYTE(8'hAA), .NAK_BYTE(8'h55)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .tx_data      (tx_data),
    .tx_write     (tx_write),
    .tx_accepted  (tx_accepted),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we && wr_count < 256) begin
      wr_addr[wr_count] = imem_addr;
      wr_data[wr_count] = imem_wdata;
      wr_count++;
    end
    if (tx_write && tx_accepted) begin
      tx_last = tx_data;
      tx_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for the reply request; an expiry shows up as a failed check.
  task automatic wait_tx(input string tag);
    int n = 0;
    while (!tx_write && n < 50) begin
      tick();
      n++;
    end
    check_output(tag, 64'(tx_write), 64'd1);
  endtask

  task automatic accept_tx();
    tx_accepted = 1'b1;
    tick();
    tx_accepted = 1'b0;
  endtask

  initial begin
    rstn        = 1'b0;
    start       = 1'b0;
    rx_data     = 8'd0;
    rx_valid    = 1'b0;
    tx_accepted = 1'b0;
    repeat (2) tick();

    // Reset state
    check_output("rst_we",    64'(imem_we),      64'd0);
    check_output("rst_addr",  64'(imem_addr),    64'd0);
    check_output("rst_wdata", 64'(imem_wdata),   64'd0);
    check_output("rst_txw",   64'(tx_write),     64'd0);
    check_output("rst_txd",   64'(tx_data),      64'd0);
    check_output("rst_busy",  64'(busy),         64'd0);
    check_output("rst_done",  64'(done),         64'd0);
    check_output("rst_err",   64'(err),          64'd0);
    check_output("rst_wl",    64'(words_loaded), 64'd0);
    rstn = 1'b1;
    tick();

    // Two-word load, acceptance after 5 cycles of tx_write
    $display("[TB] two-word load");
    wr_base = wr_count;
    tx_base = tx_count;
    pulse_start();
    check_output("t1_busy", 64'(busy), 64'd1);
    send_word(32'h0000_0002);
    send_word(32'hDEAD_BEEF);
    check_output("t1_we0",   64'(imem_we),    64'd1);
    check_output("t1_addr0", 64'(imem_addr),  64'd0);
    check_output("t1_data0", 64'(imem_wdata), 64'hDEADBEEF);
    send_word(32'h0102_0304);
    check_output("t1_we1",    64'(imem_we),    64'd1);
    check_output("t1_addr1",  64'(imem_addr),  64'd1);
    check_output("t1_data1",  64'(imem_wdata), 64'h01020304);
    check_output("t1_txw_lo", 64'(tx_write),   64'd0);
    tick();
    check_output("t1_we_drop", 64'(imem_we),  64'd0);
    check_output("t1_txw_hi",  64'(tx_write), 64'd1);
    check_output("t1_txd",     64'(tx_data),  64'hAA);
    repeat (4) tick();
    check_output("t1_txw_hold", 64'(tx_write), 64'd1);
    check_output("t1_txd_hold", 64'(tx_data),  64'hAA);
    accept_tx();
    check_output("t1_txw_end", 64'(tx_write),         64'd0);
    check_output("t1_done",    64'(done),             64'd1);
    check_output("t1_err",     64'(err),              64'd0);
    check_output("t1_busy_lo", 64'(busy),             64'd0);
    check_output("t1_wl",      64'(words_loaded),     64'd2);
    check_output("t1_nwr",     64'(wr_count - wr_base), 64'd2);
    check_output("t1_log_d0",  64'(wr_data[wr_base]),   64'hDEADBEEF);
    check_output("t1_log_a1",  64'(wr_addr[wr_base+1]), 64'd1);
    check_output("t1_ntx",     64'(tx_count - tx_base), 64'd1);

    // Zero length; acceptance in the very cycle tx_write rises
    $display("[TB] zero length");
    wr_base = wr_count;
    tx_base = tx_count;
    pulse_start();
    check_output("t2_done_clr", 64'(done), 64'd0);
    send_word(32'h0000_0000);
    check_output("t2_txw", 64'(tx_write), 64'd1);
    check_output("t2_txd", 64'(tx_data),  64'hAA);
    accept_tx();
    check_output("t2_done", 64'(done),     64'd1);
    check_output("t2_txw0", 64'(tx_write), 64'd0);
    repeat (3) tick();
    check_output("t2_ntx", 64'(tx_count - tx_base), 64'd1);
    check_output("t2_nwr", 64'(wr_count - wr_base), 64'd0);
    check_output("t2_wl",  64'(words_loaded),       64'd0);

    // Oversize length 17 > 16; tx_accepted held high before the request rises
    $display("[TB] oversize length");
    wr_base = wr_count;
    tx_base = tx_count;
    pulse_start();
    tx_accepted = 1'b1;
    send_word(32'h0000_0011);
    check_output("t3_err",  64'(err),      64'd1);
    check_output("t3_txw",  64'(tx_write), 64'd1);
    check_output("t3_txd",  64'(tx_data),  64'h55);
    tick();
    tx_accepted = 1'b0;
    check_output("t3_done", 64'(done),     64'd1);
    check_output("t3_txw0", 64'(tx_write), 64'd0);
    tick();
    check_output("t3_ntx",  64'(tx_count - tx_base), 64'd1);
    check_output("t3_txb",  64'(tx_last),            64'h55);
    check_output("t3_nwr",  64'(wr_count - wr_base), 64'd0);

    // Largest legal program: 16 words fills every address without wrap
    $display("[TB] full memory");
    wr_base = wr_count;
    pulse_start();
    check_output("t4_err_clr", 64'(err), 64'd0);
    send_word(32'h0000_0010);
    for (int i = 0; i < 16; i++) send_word(32'h1000_0000 + 32'(i));
    check_output("t4_addr", 64'(imem_addr),    64'd15);
    check_output("t4_data", 64'(imem_wdata),   64'h1000000F);
    check_output("t4_wl",   64'(words_loaded), 64'd16);
    wait_tx("t4_tx_seen");
    check_output("t4_txd",  64'(tx_data), 64'hAA);
    accept_tx();
    check_output("t4_done", 64'(done), 64'd1);
    check_output("t4_err",  64'(err),  64'd0);
    check_output("t4_nwr",  64'(wr_count - wr_base), 64'd16);
    check_output("t4_a7",   64'(wr_addr[wr_base+7]), 64'd7);

    // Full-rate bytes with strays before start, alongside start, and in ACK
    $display("[TB] stray bytes");
    wr_base = wr_count;
    tx_base = tx_count;
    send_byte(8'hFF);
    send_byte(8'hFE);
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h99);
    send_byte(8'h98);
    send_byte(8'h97);
    check_output("t5_txw", 64'(tx_write), 64'd1);
    accept_tx();
    check_output("t5_nwr",  64'(wr_count - wr_base), 64'd1);
    check_output("t5_data", 64'(wr_data[wr_base]),   64'h11223344);
    check_output("t5_addr", 64'(wr_addr[wr_base]),   64'd0);
    check_output("t5_wl",   64'(words_loaded),       64'd1);
    check_output("t5_ntx",  64'(tx_count - tx_base), 64'd1);

    // Reset after 6 of 12 data bytes
    $display("[TB] reset mid-load");
    wr_base = wr_count;
    tx_base = tx_count;
    pulse_start();
    send_word(32'h0000_0003);
    send_word(32'h5566_7788);
    send_byte(8'hAB);
    send_byte(8'hCD);
    rstn = 1'b0;
    #1;
    check_output("t6_busy",  64'(busy),         64'd0);
    check_output("t6_wl",    64'(words_loaded), 64'd0);
    check_output("t6_wdata", 64'(imem_wdata),   64'd0);
    check_output("t6_we",    64'(imem_we),      64'd0);
    check_output("t6_txw",   64'(tx_write),     64'd0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check_output("t6_nwr", 64'(wr_count - wr_base), 64'd1);
    check_output("t6_ntx", 64'(tx_count - tx_base), 64'd0);

    // Fresh load after reset, with a start pulse during DATA
    wr_base = wr_count;
    pulse_start();
    send_word(32'h0000_0002);
    send_word(32'hAABB_CCDD);
    pulse_start();
    check_output("t7_busy", 64'(busy),         64'd1);
    check_output("t7_wl1",  64'(words_loaded), 64'd1);
    send_word(32'h1234_5678);
    wait_tx("t7_tx_seen");
    accept_tx();
    check_output("t7_done", 64'(done),                 64'd1);
    check_output("t7_wl",   64'(words_loaded),         64'd2);
    check_output("t7_nwr",  64'(wr_count - wr_base),   64'd2);
    check_output("t7_a0",   64'(wr_addr[wr_base]),     64'd0);
    check_output("t7_d0",   64'(wr_data[wr_base]),     64'hAABBCCDD);
    check_output("t7_d1",   64'(wr_data[wr_base+1]),   64'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
